// File: rtl/led_pwm_driver.sv
// LED driver: off / direct counter bit / PWM breathe / tick-stepped blink pattern.
// Define LED_PWM_DRIVER_GAMMA_EN to map breathe brightness through a square-law duty.
module led_pwm_driver #(
    parameter int DIRECT_BIT    = 17,
    parameter int STEP_DIV_BITS = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Counter,
    input  logic [1:0]  Mode,
    input  logic [7:0]  Pattern,
    output logic        LED,
    output logic [7:0]  Level,
    output logic [1:0]  Phase
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        TOP  = 2'd2,
        FALL = 2'd3
    } phase_t;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_DIRECT  = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;
    localparam logic [1:0] MODE_PATTERN = 2'b11;
    localparam logic [STEP_DIV_BITS-1:0] PRESC_ONE = 1;

    // Declaration initialisers give the power-up state while Reset is still held.
    phase_t                   state     = IDLE;
    logic [7:0]               level_q   = '0;
    logic [7:0]               pwm_cnt   = '0;
    logic [STEP_DIV_BITS-1:0] prescaler = '0;
    logic [2:0]               pat_idx   = '0;
    logic                     led_q     = 1'b0;

    phase_t     state_next;
    logic [7:0] level_next;
    logic [7:0] duty;
    logic       led_next;
    logic       tick;
    logic       unused_counter;

    assign tick           = &prescaler;
    assign unused_counter = ^Counter;

`ifdef LED_PWM_DRIVER_GAMMA_EN
    logic [15:0] level_sq;
    logic        unused_sq_low;
    assign level_sq      = {8'd0, level_q} * {8'd0, level_q};
    assign duty          = level_sq[15:8];
    assign unused_sq_low = ^level_sq[7:0];
`else
    assign duty = level_q;
`endif

    // Leaving breathe mode always parks the FSM so re-entry restarts from zero.
    always_comb begin
        state_next = state;
        level_next = level_q;
        if (Mode != MODE_BREATHE) begin
            state_next = IDLE;
            level_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = RISE;
                    level_next = '0;
                end
                RISE: if (tick && level_q != 8'hFF) begin
                    level_next = level_q + 8'd1;
                    if (level_q == 8'd254) state_next = TOP;
                end
                TOP: if (tick) begin
                    state_next = FALL;
                    level_next = level_q - 8'd1;
                end
                FALL: if (tick && level_q != 8'd0) begin
                    level_next = level_q - 8'd1;
                    if (level_q == 8'd1) state_next = RISE;
                end
                default: begin
                    state_next = IDLE;
                    level_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        led_next = 1'b0;
        case (Mode)
            MODE_OFF:     led_next = 1'b0;
            MODE_DIRECT:  led_next = Counter[DIRECT_BIT];
            MODE_BREATHE: led_next = (pwm_cnt < duty);
            MODE_PATTERN: led_next = Pattern[pat_idx];
            default:      led_next = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            level_q   <= '0;
            pwm_cnt   <= '0;
            prescaler <= '0;
            pat_idx   <= '0;
            led_q     <= 1'b0;
        end else begin
            state     <= state_next;
            level_q   <= level_next;
            pwm_cnt   <= pwm_cnt + 8'd1;
            prescaler <= prescaler + PRESC_ONE;
            led_q     <= led_next;
            if (Mode != MODE_PATTERN) pat_idx <= '0;
            else if (tick)            pat_idx <= pat_idx + 3'd1;
        end
    end

    assign LED   = led_q;
    assign Level = level_q;
    assign Phase = state;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Randomised bench for led_pwm_driver (tick every 4 clocks) against an arithmetic reference model.
module tb_led_pwm_driver;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Counter = '0;
    logic [1:0]  Mode = 2'b00;
    logic [7:0]  Pattern = '0;
    logic        LED;
    logic [7:0]  Level;
    logic [1:0]  Phase;

    int n_checks = 0;
    int n_fail   = 0;

    led_pwm_driver #(.DIRECT_BIT(17), .STEP_DIV_BITS(2)) dut (
        .Clock(Clock), .Reset(Reset), .Counter(Counter), .Mode(Mode),
        .Pattern(Pattern), .LED(LED), .Level(Level), .Phase(Phase)
    );

    always #5 Clock = ~Clock;

    // Reference model: clocks since reset, ticks spent breathing, ticks spent in pattern mode.
    int cnt = 0;
    int bk  = 0;
    int pt  = 0;
    bit in_br = 0;
    bit m_led = 0;

    // One breathe period is 510 ticks: 0..254 rising, 255 at top, then 254 down to 1 falling.
    function automatic int lvl_of(bit inb, int k);
        int r;
        if (!inb) return 0;
        r = k % 510;
        return (r <= 255) ? r : 510 - r;
    endfunction

    function automatic int ph_of(bit inb, int k);
        int r;
        if (!inb) return 0;
        r = k % 510;
        if (r < 255) return 1;
        if (r == 255) return 2;
        return 3;
    endfunction

    function automatic int duty_of(int lvl);
`ifdef LED_PWM_DRIVER_GAMMA_EN
        return (lvl * lvl) / 256;
`else
        return lvl;
`endif
    endfunction

    always @(posedge Clock) begin
        bit tk;
        int lvl;
        if (Reset) begin
            cnt = 0; bk = 0; pt = 0; in_br = 0; m_led = 0;
        end else begin
            tk  = (cnt % 4) == 3;
            lvl = lvl_of(in_br, bk);
            case (Mode)
                2'b00: m_led = 0;
                2'b01: m_led = Counter[17];
                2'b10: m_led = (cnt % 256) < duty_of(lvl);
                default: m_led = Pattern[pt % 8];
            endcase
            if (Mode != 2'b10) begin in_br = 0; bk = 0; end
            else if (!in_br)   begin in_br = 1; bk = 0; end
            else if (tk)       bk++;
            if (Mode != 2'b11) pt = 0;
            else if (tk)       pt++;
            cnt++;
        end
    end

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance one clock and compare every output with the model away from the edge.
    task automatic cycle();
        @(posedge Clock);
        @(negedge Clock);
        check("led",   int'(LED),   int'(m_led));
        check("level", int'(Level), lvl_of(in_br, bk));
        check("phase", int'(Phase), ph_of(in_br, bk));
    endtask

    task automatic run(input int n, input logic [1:0] m, input bit rnd_cnt);
        for (int i = 0; i < n; i++) begin
            Mode = m;
            if (rnd_cnt) Counter = $urandom;
            cycle();
        end
    endtask

    initial begin
        int t;
        // Reset held 5 clocks with direct mode and a toggling counter bit.
        Mode = 2'b01;
        for (int i = 0; i < 5; i++) begin
            Counter = $urandom;
            Counter[17] = i[0];
            cycle();
            check("reset_led", int'(LED), 0);
        end
        Reset = 1'b0;
        run(60, 2'b01, 1);

        // Full breathe period, with a directed rise-time check.
        Reset = 1'b1; cycle(); Reset = 1'b0;
        t = 0;
        while (t < 1100 && Level != 8'd255) begin
            Mode = 2'b10;
            cycle();
            t++;
        end
        check("rise_time_ok", int'(t >= 1016 && t <= 1024), 1);
        check("top_phase", int'(Phase), 2);
        run(1100, 2'b10, 0);

        // Pattern mode with the reference sequence, then live pattern changes.
        Pattern = 8'b1010_0011;
        run(80, 2'b11, 0);
        for (int i = 0; i < 8; i++) begin
            Pattern = 8'($urandom);
            run(int'($urandom_range(3, 12)), 2'b11, 0);
        end

        // Breathe down to 100 while falling, blip to off for one clock, then back.
        Reset = 1'b1; cycle(); Reset = 1'b0;
        t = 0;
        while (t < 3000 && !(in_br && ph_of(in_br, bk) == 3 && lvl_of(in_br, bk) == 100)) begin
            Mode = 2'b10;
            cycle();
            t++;
        end
        check("reach_fall100", int'(Level), 100);
        run(1, 2'b00, 0);
        check("off_led", int'(LED), 0);
        check("off_level", int'(Level), 0);
        run(1, 2'b10, 0);
        check("reenter_phase", int'(Phase), 1);
        check("reenter_level", int'(Level), 0);
        run(40, 2'b10, 0);

        // Reset pulse mid-pattern at index 5.
        Pattern = 8'hFF;
        Mode = 2'b11;
        t = 0;
        while (t < 60 && (pt % 8) != 5) begin
            cycle();
            t++;
        end
        check("reach_idx5", pt % 8, 5);
        Reset = 1'b1; cycle(); Reset = 1'b0;
        check("rst_led", int'(LED), 0);
        run(40, 2'b11, 0);

        // Random mode sequence with occasional resets.
        for (int i = 0; i < 150; i++) begin
            Pattern = 8'($urandom);
            Reset = ($urandom_range(0, 19) == 0);
            run(int'($urandom_range(1, 40)), 2'($urandom_range(0, 3)), 1);
            Reset = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
